// File: rtl/qupls_agen_seq.sv
// ---------------------------------------------------------------------------
// qupls_agen_seq
//
// Address-generation sequencer for the load/store path. For each memory op it
// kicks the address generator, checks whether the access runs past the end of
// its 64-byte cache line, and walks one or two line addresses through the TLB.
// When the access spans a line, the agen is asked for the next-line address
// and that line is translated too. The physical address of each line, the
// span flag and any translation fault are held for the load/store unit until
// the next op is accepted.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   op_valid   in   1   start a new memory op (only looked at while idle)
//   memsz      in   3   log2 of the access size in bytes, captured with op_valid
//   flush      in   1   abort the op in flight
//   agen_out   out  1   one-cycle pulse: agen operands are valid
//   agen_next  out  1   ask the agen for the next-cache-line address
//   agen_res   in   64  agen virtual address
//   agen_resv  in   1   agen result valid (sticky in the agen)
//   tlb_v      out  1   one-cycle pulse that clears the agen's sticky valid
//   tlb_req    out  1   TLB lookup request
//   tlb_vadr   out  64  virtual address for the lookup
//   tlb_ack    in   1   TLB lookup complete
//   tlb_padr   in   64  physical address, valid with tlb_ack
//   tlb_fault  in   1   translation fault, valid with tlb_ack
//   busy       out  1   sequencer is not idle
//   done       out  1   one-cycle completion pulse
//   span       out  1   access crosses into the next 64-byte line
//   fault      out  1   a translation fault (or bad next-line address) occurred
//   padr0      out  64  physical address of the first line
//   padr1      out  64  physical address of the second line
// ---------------------------------------------------------------------------
module qupls_agen_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  memsz,
  input  logic        flush,
  output logic        agen_out,
  output logic        agen_next,
  input  logic [63:0] agen_res,
  input  logic        agen_resv,
  output logic        tlb_v,
  output logic        tlb_req,
  output logic [63:0] tlb_vadr,
  input  logic        tlb_ack,
  input  logic [63:0] tlb_padr,
  input  logic        tlb_fault,
  output logic        busy,
  output logic        done,
  output logic        span,
  output logic        fault,
  output logic [63:0] padr0,
  output logic [63:0] padr1
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_A1  = 3'd1;
  localparam logic [2:0] TLB1     = 3'd2;
  localparam logic [2:0] NEXT_REQ = 3'd3;
  localparam logic [2:0] WAIT_A2  = 3'd4;
  localparam logic [2:0] TLB2     = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [2:0]  memsz_q, memsz_d;
  logic [63:0] vadr0_q, vadr0_d;
  logic [63:0] vadr1_q, vadr1_d;
  logic [63:0] padr0_q, padr0_d;
  logic [63:0] padr1_q, padr1_d;
  logic        span_q, span_d;
  logic        fault_q, fault_d;

  logic [5:0]  sizeMask;
  logic        spanCarry;
  logic        flushActive;

  // Byte-offset of the last byte minus the first: 2^memsz - 1, formed as the
  // low memsz bits set. Sizes of 64 bytes or more saturate at a full line.
  assign sizeMask = ~(6'h3F << memsz_q);

  // Carry out of offset + sizeMask in 6 bits. Since 63 - m == ~m for a 6-bit
  // m, the carry happens exactly when the offset exceeds ~sizeMask.
  assign spanCarry = (agen_res[5:0] > ~sizeMask);

  assign flushActive = flush && (state_q != IDLE);

  // Next-state and output decode. Flush overrides whatever the state would
  // have done (including a coincident TLB ack), and reset masks all pulses.
  always_comb begin
    state_d   = state_q;
    memsz_d   = memsz_q;
    vadr0_d   = vadr0_q;
    vadr1_d   = vadr1_q;
    padr0_d   = padr0_q;
    padr1_d   = padr1_q;
    span_d    = span_q;
    fault_d   = fault_q;
    agen_out  = 1'b0;
    agen_next = 1'b0;
    tlb_v     = 1'b0;
    tlb_req   = 1'b0;
    tlb_vadr  = 64'd0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          agen_out = 1'b1;
          memsz_d  = memsz;
          span_d   = 1'b0;
          fault_d  = 1'b0;
          padr0_d  = 64'd0;
          padr1_d  = 64'd0;
          state_d  = WAIT_A1;
        end
      end

      WAIT_A1: begin
        if (agen_resv) begin
          vadr0_d = agen_res;
          span_d  = spanCarry;
          state_d = TLB1;
        end
      end

      TLB1: begin
        tlb_req  = 1'b1;
        tlb_vadr = vadr0_q;
        if (tlb_ack) begin
          tlb_v   = 1'b1;
          padr0_d = tlb_padr;
          fault_d = tlb_fault;
          // A faulting first line makes the second lookup pointless.
          state_d = (span_q && !tlb_fault) ? NEXT_REQ : DONE;
        end
      end

      // Separate cycle so the agen restart never coincides with tlb_v.
      NEXT_REQ: begin
        agen_out  = 1'b1;
        agen_next = 1'b1;
        state_d   = WAIT_A2;
      end

      WAIT_A2: begin
        agen_next = 1'b1;
        if (agen_resv) begin
          vadr1_d = agen_res;
          // The next-line address must sit on a line boundary; anything else
          // means the agen handed back garbage, so report it as a fault.
          if (agen_res[5:0] != 6'd0) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = TLB2;
          end
        end
      end

      TLB2: begin
        tlb_req  = 1'b1;
        tlb_vadr = vadr1_q;
        if (tlb_ack) begin
          tlb_v   = 1'b1;
          padr1_d = tlb_padr;
          fault_d = fault_q | tlb_fault;
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flushActive) begin
      state_d   = IDLE;
      tlb_v     = 1'b1;
      tlb_req   = 1'b0;
      tlb_vadr  = 64'd0;
      agen_out  = 1'b0;
      agen_next = 1'b0;
      done      = 1'b0;
      vadr0_d   = vadr0_q;
      vadr1_d   = vadr1_q;
      padr0_d   = padr0_q;
      padr1_d   = padr1_q;
      span_d    = span_q;
      fault_d   = fault_q;
    end

    if (rst) begin
      agen_out  = 1'b0;
      agen_next = 1'b0;
      tlb_v     = 1'b0;
      tlb_req   = 1'b0;
      tlb_vadr  = 64'd0;
      done      = 1'b0;
    end
  end

  // State registers with synchronous reset clearing every held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      memsz_q <= 3'd0;
      vadr0_q <= 64'd0;
      vadr1_q <= 64'd0;
      padr0_q <= 64'd0;
      padr1_q <= 64'd0;
      span_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      memsz_q <= memsz_d;
      vadr0_q <= vadr0_d;
      vadr1_q <= vadr1_d;
      padr0_q <= padr0_d;
      padr1_q <= padr1_d;
      span_q  <= span_d;
      fault_q <= fault_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign span  = span_q;
  assign fault = fault_q;
  assign padr0 = padr0_q;
  assign padr1 = padr1_q;

endmodule

// File: tb/tb_qupls_agen_seq.sv
// ---------------------------------------------------------------------------
// tb_qupls_agen_seq
//
// Bench for the address-generation sequencer. The driver plays both the agen
// and the TLB; each completed op's expected result is queued when the op is
// started and compared when the sequencer pulses done.
// ---------------------------------------------------------------------------
module tb_qupls_agen_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  memsz;
  logic        flush;
  logic        agen_out;
  logic        agen_next;
  logic [63:0] agen_res;
  logic        agen_resv;
  logic        tlb_v;
  logic        tlb_req;
  logic [63:0] tlb_vadr;
  logic        tlb_ack;
  logic [63:0] tlb_padr;
  logic        tlb_fault;
  logic        busy;
  logic        done;
  logic        span;
  logic        fault;
  logic [63:0] padr0;
  logic [63:0] padr1;

  qupls_agen_seq dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .memsz     (memsz),
    .flush     (flush),
    .agen_out  (agen_out),
    .agen_next (agen_next),
    .agen_res  (agen_res),
    .agen_resv (agen_resv),
    .tlb_v     (tlb_v),
    .tlb_req   (tlb_req),
    .tlb_vadr  (tlb_vadr),
    .tlb_ack   (tlb_ack),
    .tlb_padr  (tlb_padr),
    .tlb_fault (tlb_fault),
    .busy      (busy),
    .done      (done),
    .span      (span),
    .fault     (fault),
    .padr0     (padr0),
    .padr1     (padr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spanE;
    logic        faultE;
    logic [63:0] padr0E;
    logic [63:0] padr1E;
    int          tlbVE;
    logic        agenNextE;
  } expT;

  expT  sbQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   tlbVCount = 0;
  logic agenNextSeen = 1'b0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: on every done pulse, pop the oldest expectation and
  // compare the held results plus the per-op tlb_v / agen_next history.
  always @(negedge clk) begin : monitor
    expT e;
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 64'd1, 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("span", 64'(span), 64'(e.spanE));
        checkOutput("fault", 64'(fault), 64'(e.faultE));
        checkOutput("padr0", padr0, e.padr0E);
        checkOutput("padr1", padr1, e.padr1E);
        checkOutput("tlbVPulses", 64'(tlbVCount), 64'(e.tlbVE));
        checkOutput("agenNextSeen", 64'(agenNextSeen), 64'(e.agenNextE));
      end
    end
    if (agen_out && !busy) begin
      tlbVCount    = 0;
      agenNextSeen = 1'b0;
    end
    if (tlb_v) tlbVCount++;
    if (agen_next) agenNextSeen = 1'b1;
  end

  task automatic startOp(input logic [2:0] m);
    op_valid = 1'b1;
    memsz    = m;
    @(negedge clk);
    checkOutput("startAgenOut", 64'(agen_out), 64'd1);
    checkOutput("startBusy", 64'(busy), 64'd0);
    tick;
    op_valid = 1'b0;
  endtask

  // Two cycles in a WAIT state: a stray TLB ack first (must be ignored),
  // then the agen result.
  task automatic giveAgen(input logic [63:0] v, input logic expNext);
    tlb_ack   = 1'b1;
    tlb_padr  = 64'hDEAD_BEEF_0000_0000;
    tlb_fault = 1'b1;
    agen_resv = 1'b0;
    @(negedge clk);
    checkOutput("waitBusy", 64'(busy), 64'd1);
    checkOutput("waitAgenNext", 64'(agen_next), 64'(expNext));
    checkOutput("waitTlbV", 64'(tlb_v), 64'd0);
    tick;
    tlb_ack   = 1'b0;
    tlb_fault = 1'b0;
    tlb_padr  = 64'd0;
    agen_resv = 1'b1;
    agen_res  = v;
    @(negedge clk);
    checkOutput("resvAgenNext", 64'(agen_next), 64'(expNext));
    tick;
  endtask

  // TLB lookup with ackDelay stall cycles; op_valid is held high meanwhile
  // to show it is ignored while busy.
  task automatic doTlb(input logic [63:0] vExp, input logic [63:0] p, input logic f, input int ackDelay);
    for (int i = 0; i < ackDelay; i++) begin
      op_valid = 1'b1;
      @(negedge clk);
      checkOutput("stallTlbReq", 64'(tlb_req), 64'd1);
      checkOutput("stallTlbVadr", tlb_vadr, vExp);
      checkOutput("stallTlbV", 64'(tlb_v), 64'd0);
      checkOutput("stallAgenOut", 64'(agen_out), 64'd0);
      tick;
    end
    op_valid  = 1'b0;
    tlb_ack   = 1'b1;
    tlb_padr  = p;
    tlb_fault = f;
    @(negedge clk);
    checkOutput("ackTlbVadr", tlb_vadr, vExp);
    checkOutput("ackTlbV", 64'(tlb_v), 64'd1);
    tick;
    tlb_ack   = 1'b0;
    tlb_fault = 1'b0;
    tlb_padr  = 64'd0;
    agen_resv = 1'b0;
  endtask

  task automatic nextReq;
    @(negedge clk);
    checkOutput("nextAgenOut", 64'(agen_out), 64'd1);
    checkOutput("nextAgenNext", 64'(agen_next), 64'd1);
    checkOutput("nextTlbV", 64'(tlb_v), 64'd0);
    tick;
  endtask

  task automatic waitDone;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!done && waited < 8) begin
      tick;
      @(negedge clk);
      waited++;
    end
    checkOutput("doneLatency", 64'(waited), 64'd0);
    tick;
    @(negedge clk);
    checkOutput("donePulseEnds", 64'(done), 64'd0);
    checkOutput("idleBusy", 64'(busy), 64'd0);
    tick;
  endtask

  // Full op: the reference expectation is formed here from the access
  // geometry, then the agen/TLB handshakes are played out.
  task automatic applyStimulus(input logic [2:0] m, input logic [63:0] v0, input logic [63:0] v1,
                               input logic [63:0] p0, input logic [63:0] p1,
                               input logic f1, input logic f2, input int ackDelay);
    expT  e;
    int   lastByte;
    logic spanGo;
    logic aligned;
    lastByte = int'(v0[5:0]) + (1 << m) - 1;
    e.spanE  = (lastByte >= 64);
    spanGo   = e.spanE && !f1;
    aligned  = (v1[5:0] == 6'd0);
    e.faultE    = f1 | (spanGo && !aligned) | (spanGo && aligned && f2);
    e.padr0E    = p0;
    e.padr1E    = (spanGo && aligned) ? p1 : 64'd0;
    e.tlbVE     = (spanGo && aligned) ? 2 : 1;
    e.agenNextE = spanGo;
    sbQ.push_back(e);

    startOp(m);
    giveAgen(v0, 1'b0);
    doTlb(v0, p0, f1, ackDelay);
    if (spanGo) begin
      nextReq();
      giveAgen(v1, 1'b1);
      if (aligned) doTlb(v1, p1, f2, 1);
    end
    waitDone();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst       = 1'b1;
    op_valid  = 1'b0;
    memsz     = 3'd0;
    flush     = 1'b0;
    agen_res  = 64'd0;
    agen_resv = 1'b0;
    tlb_ack   = 1'b0;
    tlb_padr  = 64'd0;
    tlb_fault = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstSpan", 64'(span), 64'd0);
    checkOutput("rstFault", 64'(fault), 64'd0);
    checkOutput("rstPadr0", padr0, 64'd0);
    checkOutput("rstPadr1", padr1, 64'd0);
    checkOutput("rstTlbVadr", tlb_vadr, 64'd0);
    checkOutput("rstTlbReq", 64'(tlb_req), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    // Non-spanning, slow TLB; spanning; size boundaries; faults.
    applyStimulus(3'd3, 64'h1000_0038, 64'd0,          64'h8_0038, 64'd0,      1'b0, 1'b0, 3);
    applyStimulus(3'd3, 64'h1000_003C, 64'h1000_0040, 64'h8_003C, 64'h9_0000, 1'b0, 1'b0, 0);
    applyStimulus(3'd4, 64'h2000_0030, 64'd0,          64'hA_0030, 64'd0,      1'b0, 1'b0, 1);
    applyStimulus(3'd4, 64'h2000_0031, 64'h2000_0040, 64'hA_0031, 64'hB_0000, 1'b0, 1'b0, 2);
    applyStimulus(3'd0, 64'h3000_003F, 64'd0,          64'hC_003F, 64'd0,      1'b0, 1'b0, 0);
    applyStimulus(3'd3, 64'h4000_003C, 64'h4000_0040, 64'hD_003C, 64'hE_0000, 1'b1, 1'b0, 1);
    applyStimulus(3'd2, 64'h5000_003E, 64'h5000_0041, 64'hF_003E, 64'h1_0000, 1'b0, 1'b0, 0);
    applyStimulus(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7_FFFF, 64'h6_0000, 1'b0, 1'b1, 1);

    // Flush in WAIT_A2, coinciding with the agen result.
    startOp(3'd3);
    giveAgen(64'h6000_003C, 1'b0);
    doTlb(64'h6000_003C, 64'h2_003C, 1'b0, 0);
    nextReq();
    flush     = 1'b1;
    agen_resv = 1'b1;
    agen_res  = 64'h6000_0040;
    @(negedge clk);
    checkOutput("flushTlbV", 64'(tlb_v), 64'd1);
    checkOutput("flushAgenNext", 64'(agen_next), 64'd0);
    checkOutput("flushAgenOut", 64'(agen_out), 64'd0);
    checkOutput("flushDone", 64'(done), 64'd0);
    tick;
    flush     = 1'b0;
    agen_resv = 1'b0;
    @(negedge clk);
    checkOutput("postFlushBusy", 64'(busy), 64'd0);
    checkOutput("postFlushDone", 64'(done), 64'd0);
    tick;
    applyStimulus(3'd3, 64'h7000_0008, 64'd0, 64'h3_0008, 64'd0, 1'b0, 1'b0, 1);

    // Reset in TLB2 with an ack (and flush) in the same cycle.
    startOp(3'd3);
    giveAgen(64'h8000_003C, 1'b0);
    doTlb(64'h8000_003C, 64'h4_003C, 1'b0, 0);
    nextReq();
    giveAgen(64'h8000_0040, 1'b1);
    @(negedge clk);
    checkOutput("tlb2Vadr", tlb_vadr, 64'h8000_0040);
    rst       = 1'b1;
    flush     = 1'b1;
    tlb_ack   = 1'b1;
    tlb_padr  = 64'h5_5555_0000;
    tick;
    rst       = 1'b0;
    flush     = 1'b0;
    tlb_ack   = 1'b0;
    tlb_padr  = 64'd0;
    @(negedge clk);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstPadr0", padr0, 64'd0);
    checkOutput("midRstPadr1", padr1, 64'd0);
    checkOutput("midRstSpan", 64'(span), 64'd0);
    checkOutput("midRstFault", 64'(fault), 64'd0);
    checkOutput("midRstTlbReq", 64'(tlb_req), 64'd0);
    checkOutput("midRstTlbVadr", tlb_vadr, 64'd0);
    checkOutput("midRstTlbV", 64'(tlb_v), 64'd0);
    checkOutput("midRstDone", 64'(done), 64'd0);
    tick;

    repeat (3) tick;
    checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/qupls_agen_seq.md
QUPLS_AGEN_SEQ -- requirements
Module: qupls_agen_seq
Address-generation sequencer for the load/store path: drives the agen, detects cache-line spans and walks both lines through the TLB. Cache line is 64 bytes; addresses are 64 bits.

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: op_valid  in  1  start a new memory op; sampled only in IDLE.
REQ-004 SHALL have: memsz  in  3  log2 of access byte count (0=1B .. 4=16B); captured with op_valid.
REQ-005 SHALL have: flush  in  1  abort the current op.
REQ-006 SHALL have: agen_out  out  1  one-cycle pulse telling the agen its operands are valid.
REQ-007 SHALL have: agen_next  out  1  requests the agen's next-cache-line address.
REQ-008 SHALL have: agen_res  in  64  agen virtual address.
REQ-009 SHALL have: agen_resv  in  1  agen result valid (sticky until cleared).
REQ-010 SHALL have: tlb_v  out  1  one-cycle pulse that clears the agen's sticky valid.
REQ-011 SHALL have: tlb_req  out  1  TLB lookup request.
REQ-012 SHALL have: tlb_vadr  out  64  virtual address presented with tlb_req.
REQ-013 SHALL have: tlb_ack  in  1  TLB lookup complete.
REQ-014 SHALL have: tlb_padr  in  64  physical address; valid with tlb_ack.
REQ-015 SHALL have: tlb_fault  in  1  translation fault; valid with tlb_ack.
REQ-016 SHALL have: busy  out  1  high in every state except IDLE.
REQ-017 SHALL have: done  out  1  one-cycle completion pulse.
REQ-018 SHALL have: span  out  1  the access crosses into the next 64-byte line.
REQ-019 SHALL have: fault  out  1  a translation fault occurred.
REQ-020 SHALL have: padr0 / padr1  out  64 each  physical addresses of line 0 and line 1.

Function
REQ-021 SHALL implement the states IDLE, WAIT_A1, TLB1, NEXT_REQ, WAIT_A2, TLB2, DONE.
REQ-022 In IDLE with op_valid=1: pulse agen_out in that cycle, capture memsz, clear span/fault/padr0/padr1, go to WAIT_A1.
REQ-023 In WAIT_A1 with agen_resv=1: capture vadr0=agen_res, compute span, go to TLB1.
  - span = carry-out of the 6-bit sum vadr0[5:0] + (2^memsz - 1).
REQ-024 In TLB1: hold tlb_req=1 and tlb_vadr=vadr0 until tlb_ack.
REQ-025 On tlb_ack in TLB1:
  - capture padr0=tlb_padr and fault=tlb_fault;
  - pulse tlb_v in the same cycle;
  - go to NEXT_REQ if span=1 and tlb_fault=0, else go to DONE.
REQ-026 NEXT_REQ lasts exactly one cycle: agen_out=1 and agen_next=1, then go to WAIT_A2.
  - agen_out is never asserted in the same cycle as tlb_v.
REQ-027 agen_next SHALL be held high from NEXT_REQ through the WAIT_A2 cycle in which agen_resv=1.
REQ-028 In WAIT_A2 with agen_resv=1: capture vadr1=agen_res, go to TLB2.
  - vadr1[5:0] is not 0: set fault=1 and go to DONE instead.
REQ-029 TLB2 SHALL behave as TLB1, using vadr1, capturing padr1 and OR-ing tlb_fault into fault, then going to DONE.
REQ-030 DONE lasts one cycle: done=1, then go to IDLE.
  - padr0, padr1, span and fault hold until the next accepted op_valid.
REQ-031 tlb_req SHALL remain asserted with a stable tlb_vadr across any number of tlb_ack=0 cycles.
REQ-032 agen_resv=1 outside WAIT_A1/WAIT_A2 SHALL be ignored.
REQ-033 tlb_ack outside TLB1/TLB2 SHALL be ignored.
REQ-034 op_valid while busy=1 SHALL be ignored.
REQ-035 flush=1 in any non-IDLE state:
  - go to IDLE next cycle;
  - pulse tlb_v in the flush cycle;
  - drop tlb_req, agen_next and agen_out;
  - no done pulse.
REQ-036 flush=1 and tlb_ack=1 in the same cycle: flush wins and padr0/padr1 are not updated.
REQ-037 Address arithmetic SHALL be 64-bit, with no wrap detection beyond bit 63.

Reset
REQ-038 On rst, go to IDLE; all outputs 0, including padr0, padr1, span, fault, tlb_vadr.
REQ-039 rst mid-operation SHALL take priority over flush and every handshake input.

Verification
REQ-040 Non-spanning access: memsz=3, agen_res=0x1000_0038, agen_resv two cycles after agen_out, tlb_ack after 3 cycles with tlb_padr=0x8_0038 -> span=0, one tlb_v pulse, done with padr0=0x8_0038, agen_next never high.
REQ-041 Spanning access: memsz=3, agen_res=0x1000_003C, then 0x1000_0040 -> span=1.
  - agen_out in NEXT_REQ falls one cycle after the first tlb_v.
  - Second tlb_vadr=0x1000_0040.
  - done with padr0 and padr1 both captured; two tlb_v pulses.
REQ-042 Boundary: memsz=4 at vadr[5:0]=0x30 -> span=0; at 0x31 -> span=1. memsz=0 at 0x3F -> span=0.
REQ-043 Fault: spanning op with tlb_fault=1 on the first ack -> fault=1, no NEXT_REQ, done one cycle after the ack.
REQ-044 Flush: flush in WAIT_A2 -> tlb_v pulse, IDLE next cycle, no done; a new op_valid then completes normally.
REQ-045 Reset in TLB2 with tlb_ack=1 -> all outputs 0 next cycle and padr1 not updated.
